// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master engines: FSM state encoding,
// quarter-bit phase constants and bus-level protocol constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK,
        ST_LOAD,
        ST_DATA,
        ST_STOP
    } state_t;

    // Quarter-bit phases; SCL is low in Q0/Q1 and released in Q2/Q3.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_ACK   = 1'b0;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit prescaler: pulses qtick once every CLK_DIV cycles while run
// is high. hold freezes the count (FIFO stall or slave clock stretching);
// dropping run returns the count to zero so every transfer starts aligned.
module i2c_qtick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic qtick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign qtick = run && !hold && (cnt == CW'(CLK_DIV - 1));

    // Free-running divider, cleared when idle and frozen while held.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= qtick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_tx.sv
// I2C master write engine. Issues START, sends {addr,W}, then pops bytes
// from a show-ahead FIFO and shifts them out MSB-first, checking the slave
// ACK after each byte, and finishes with STOP.
// Optional: define I2C_STRETCH_EN to honour slave clock stretching on scl_i.
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int AW      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic [6:0]  addr,
    input  logic [AW:0] len,
    output logic        fifo_rd,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i,
    input  logic        scl_i,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic [AW:0] bytes_sent
);

    state_t      state, state_nxt;
    logic [1:0]  phase;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [6:0]  addr_r;
    logic [AW:0] len_r;
    logic        is_data;   // byte currently on the wire came from the FIFO
    logic        qtick;
    logic        run;
    logic        hold;
    logic        go_ok;
    logic        bit_end;

    assign run     = (state != ST_IDLE);
    // A go coinciding with the done pulse is dropped along with go-while-busy.
    assign go_ok   = go && (state == ST_IDLE) && !done;
    assign bit_end = qtick && (phase == Q3);

`ifdef I2C_STRETCH_EN
    // A slave holding SCL low while we have released it stretches the phase.
    assign hold = ((state == ST_LOAD) && fifo_empty) ||
                  (phase[1] && !scl_oe && !scl_i);
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign hold = (state == ST_LOAD) && fifo_empty;
`endif

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .hold  (hold),
        .qtick (qtick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; every bit-level transition lands on the Q3 boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (go_ok) state_nxt = ST_START;
            ST_START: if (bit_end) state_nxt = ST_ADDR;
            ST_ADDR,
            ST_DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = ST_ACK;
            ST_ACK:   if (bit_end)
                          state_nxt = (nack || bytes_sent == len_r) ? ST_STOP : ST_LOAD;
            ST_LOAD:  if (!fifo_empty) state_nxt = ST_DATA;
            ST_STOP:  if (bit_end) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Pad enables and FIFO pop decoded from state and quarter phase.
    always_comb begin
        scl_oe  = 1'b0;
        sda_oe  = 1'b0;
        fifo_rd = 1'b0;
        case (state)
            ST_START: sda_oe = phase[1];
            ST_ADDR,
            ST_DATA: begin
                scl_oe = ~phase[1];
                sda_oe = ~shreg[7];
            end
            ST_ACK:   scl_oe = ~phase[1];
            ST_LOAD: begin
                scl_oe  = 1'b1;
                fifo_rd = !fifo_empty;
            end
            ST_STOP: begin
                scl_oe = (phase == Q0);
                sda_oe = ~phase[1];
            end
            default: ;
        endcase
    end

    // Phase counter, shift register, transfer bookkeeping and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase      <= Q0;
            bit_cnt    <= '0;
            shreg      <= '0;
            addr_r     <= '0;
            len_r      <= '0;
            is_data    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            nack       <= 1'b0;
            bytes_sent <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) phase <= Q0;
            else if (qtick)       phase <= phase + 2'd1;

            case (state)
                ST_IDLE: if (go_ok) begin
                    addr_r     <= addr;
                    len_r      <= len;
                    busy       <= 1'b1;
                    nack       <= 1'b0;
                    bytes_sent <= '0;
                    is_data    <= 1'b0;
                end
                ST_START: if (bit_end) begin
                    shreg   <= {addr_r, I2C_WRITE};
                    bit_cnt <= '0;
                end
                ST_ADDR,
                ST_DATA: if (bit_end) begin
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                // ACK slot is sampled mid-high-phase, at the end of Q2.
                ST_ACK: if (qtick && phase == Q2) begin
                    if (sda_i != I2C_ACK)
                        nack <= 1'b1;
                    else if (is_data && bytes_sent != len_r)
                        bytes_sent <= bytes_sent + 1'b1;
                end
                // The load cycle doubles as the first cycle of DATA Q0.
                ST_LOAD: if (!fifo_empty) begin
                    shreg   <= fifo_dout;
                    bit_cnt <= '0;
                    is_data <= 1'b1;
                end
                ST_STOP: if (bit_end) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Randomized bench for i2c_master_tx: a show-ahead FIFO model, an open-drain
// bus with an ACK/NACK slave and a bus decoder that rebuilds the byte stream.
// Expected bytes, ACKs, pop counts and durations come from transfer-level rules.
module tb_i2c_master_tx;

    localparam int CD = 2;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go  = 1'b0;
    logic [6:0]    addr = '0;
    logic [AW:0]   len  = '0;
    logic          fifo_rd, fifo_empty;
    logic [7:0]    fifo_dout;
    logic          scl_oe, sda_oe, sda_i, scl_i;
    logic          busy, done, nack;
    logic [AW:0]   bytes_sent;

    // FIFO model
    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush  = 1'b0;

    // Slave / bus
    logic slv_sda = 1'b0;
    logic slv_scl = 1'b0;
    assign scl_i = !scl_oe && !slv_scl;
    assign sda_i = !sda_oe && !slv_sda;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr[3:0]];

    i2c_master_tx #(.CLK_DIV(CD), .AW(AW)) dut (
        .clk(clk), .rst(rst), .go(go), .addr(addr), .len(len),
        .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i), .scl_i(scl_i),
        .busy(busy), .done(done), .nack(nack), .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flush)                        rd_ptr <= wr_ptr;
        else if (fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    // Bus decoder + slave
    logic       scl_p = 1'b1, sda_p = 1'b1;
    int         bitcnt = 0, byteidx = 0, nack_idx = -1;
    int         starts = 0, stops = 0;
    logic [7:0] shr = '0;
    logic [7:0] bus_q [$];
    bit         ack_q [$];
    bit         stretch_arm = 1'b0;
    int         stretch_cnt = 0;

    always @(negedge clk) begin
        logic s, d;
        s = scl_i;
        d = sda_i;
        if (stretch_cnt > 0) stretch_cnt--;
        if (s && scl_p && sda_p && !d) begin
            starts++; bitcnt = 0; byteidx = 0;
        end else if (s && scl_p && !sda_p && d) begin
            stops++;
        end
        if (!scl_p && s) begin
            if (bitcnt < 8) shr = {shr[6:0], d};
            else begin bus_q.push_back(shr); ack_q.push_back(d); end
            bitcnt++;
        end
        if (scl_p && !s) begin
            if (bitcnt == 8) slv_sda = (byteidx != nack_idx);
            else if (bitcnt == 9) begin slv_sda = 1'b0; bitcnt = 0; byteidx++; end
            if (stretch_arm && bitcnt == 3) begin stretch_arm = 1'b0; stretch_cnt = 24; end
        end
        slv_scl = (stretch_cnt > 0);
        scl_p = s;
        sda_p = d;
    end

    // Checking
    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] exp_d [$];
    int st0, sp0, rd0;

    task automatic push_fifo(input logic [7:0] v);
        mem[wr_ptr[3:0]] = v;
        wr_ptr++;
    endtask

    task automatic flush_fifo();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
    endtask

    task automatic start_xfer(input logic [6:0] a, input int n, input int nk);
        @(negedge clk);
        nack_idx = nk;
        bus_q.delete(); ack_q.delete();
        st0 = starts; sp0 = stops; rd0 = rd_ptr;
        addr = a; len = (AW+1)'(n); go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    // Waits for done and checks the whole transfer against the model.
    // extra < 0 skips the duration check (stalled transfers).
    task automatic finish_xfer(input logic [6:0] a, input int n, input int nk,
                               input int extra, input bit go_mid);
        int cyc = 0;
        bit seen = 0;
        int nb, pops, bs;
        logic [7:0] e;
        while (cyc < 6000) begin
            @(posedge clk); cyc++; #1;
            go = 1'b0;
            if (done) begin seen = 1; break; end
            if (go_mid && cyc == 40) begin go = 1'b1; addr = ~a; end
        end
        chk("done_seen", seen, 1);
        nb   = (nk < 0) ? n + 1 : nk + 1;
        pops = (nk < 0) ? n : nk;
        bs   = (nk < 0) ? n : ((nk == 0) ? 0 : nk - 1);
        if (extra >= 0) chk("duration", cyc, 4*CD*(2 + 9*nb) + extra);
        // go in the done cycle must be ignored
        go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        chk("done_pulse_1cyc", done, 0);
        chk("busy_after_done", busy, 0);
        chk("nack", nack, (nk >= 0));
        chk("bytes_sent", bytes_sent, bs);
        chk("fifo_pops", rd_ptr - rd0, pops);
        chk("starts", starts - st0, 1);
        chk("stops", stops - sp0, 1);
        chk("bus_bytes", bus_q.size(), nb);
        for (int i = 0; i < nb && i < bus_q.size(); i++) begin
            e = (i == 0) ? {a, 1'b0} : exp_d[i-1];
            chk("bus_byte", bus_q[i], e);
            chk("bus_ack", ack_q[i], (nk == i));
        end
        chk("fifo_left", wr_ptr - rd_ptr, n - pops);
        flush_fifo();
    endtask

    initial begin
        int w;
        bit low_seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_bytes_sent", bytes_sent, 0);
        @(negedge clk) rst = 1'b0;

        // Two data bytes, all ACKed, plus a go while busy
        exp_d = '{8'hA5, 8'h3C};
        push_fifo(8'hA5); push_fifo(8'h3C);
        start_xfer(7'h50, 2, -1);
        finish_xfer(7'h50, 2, -1, 0, 1'b1);

        // Address-only probe
        exp_d.delete();
        start_xfer(7'h3F, 0, -1);
        finish_xfer(7'h3F, 0, -1, 0, 1'b0);

        // NACK on the second data byte
        exp_d = '{8'h11, 8'h22, 8'h33};
        push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33);
        start_xfer(7'h2A, 3, 2);
        finish_xfer(7'h2A, 3, 2, 0, 1'b0);

        // FIFO empty at go: master stalls with SCL low
        exp_d = '{8'h5A};
        start_xfer(7'h19, 1, -1);
        w = 0;
        while (ack_q.size() < 1 && w < 3000) begin @(negedge clk); w++; end
        chk("stall_addr_ack", ack_q.size(), 1);
        repeat (20) @(negedge clk);
        low_seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!scl_oe || !busy) low_seen = 1'b1;
        end
        chk("stall_scl_held", low_seen, 0);
        chk("stall_no_pop", rd_ptr - rd0, 0);
        push_fifo(8'h5A);
        finish_xfer(7'h19, 1, -1, -1, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 12; t++) begin
            logic [6:0] a;
            logic [7:0] v;
            int n, nk;
            a = 7'($urandom);
            n = int'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) nk = int'($urandom_range(0, n));
            else                           nk = -1;
            exp_d.delete();
            for (int i = 0; i < n; i++) begin
                v = 8'($urandom);
                exp_d.push_back(v);
                push_fifo(v);
            end
            start_xfer(a, n, nk);
            finish_xfer(a, n, nk, 0, t[0]);
        end

`ifdef I2C_STRETCH_EN
        // Slave stretches the fourth address bit by 20 cycles
        exp_d.delete();
        stretch_arm = 1'b1;
        start_xfer(7'h3F, 0, -1);
        finish_xfer(7'h3F, 0, -1, 20, 1'b0);
`endif

        // Reset in the SCL-low half of a data bit
        push_fifo(8'h00); push_fifo(8'hFF); push_fifo(8'h0F);
        start_xfer(7'h33, 3, -1);
        w = 0;
        while (rd_ptr == rd0 && w < 3000) begin @(negedge clk); w++; end
        chk("rst_mid_pop_seen", rd_ptr - rd0, 1);
        w = 0;
        while (scl_oe && w < 100) begin @(negedge clk); w++; end
        while (!scl_oe && w < 200) begin @(negedge clk); w++; end
        chk("rst_mid_low_phase", scl_oe, 1);
        sp0 = stops;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_scl_oe", scl_oe, 0);
        chk("rst_mid_sda_oe", sda_oe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_fifo_rd", fifo_rd, 0);
        @(negedge clk) rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_stop", stops - sp0, 0);
        chk("rst_mid_idle", scl_oe | sda_oe | busy, 0);
        flush_fifo();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
